// File: rtl/cpu8_pkg.sv
// cpu8_pkg: shared definitions for the 8-bit CPU register file path.
//   DW_DEF       default datapath width
//   REG_A..REG_D destination select encodings (reg_sel4)
//   wb_state_t   write-back queue occupancy (EMPTY/ONE/TWO)
package cpu8_pkg;
    localparam int DW_DEF = 8;

    localparam logic [1:0] REG_A = 2'd0;
    localparam logic [1:0] REG_B = 2'd1;
    localparam logic [1:0] REG_C = 2'd2;
    localparam logic [1:0] REG_D = 2'd3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } wb_state_t;
endpackage

// File: rtl/wb_skid_buf.sv
// wb_skid_buf: two-entry {sel,data} write-back queue storage.
// Occupancy is owned by the caller's FSM and fed back in through occ, so
// the slot contents and the occupancy can never disagree.
//   clk, rst            clock, synchronous active-high reset
//   occ                 current occupancy (EMPTY/ONE/TWO)
//   push                accepted transfer this edge (caller guarantees occ != TWO)
//   pop                 head entry committed this edge (caller guarantees occ != EMPTY)
//   in_sel, in_data     entry to enqueue
//   head_sel, head_data oldest entry (slot 0)
//   next_sel, next_data second entry (slot 1), meaningful only when occ == TWO
module wb_skid_buf
    import cpu8_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  wb_state_t       occ,
    input  logic            push,
    input  logic            pop,
    input  logic [1:0]      in_sel,
    input  logic [DW-1:0]   in_data,
    output logic [1:0]      head_sel,
    output logic [DW-1:0]   head_data,
    output logic [1:0]      next_sel,
    output logic [DW-1:0]   next_data
);
    logic [1:0][1:0]    sel_q;
    logic [1:0][DW-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= '0;
            data_q <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    // Enqueue behind whatever is already held.
                    if (occ == EMPTY) begin
                        sel_q[0]  <= in_sel;
                        data_q[0] <= in_data;
                    end else begin
                        sel_q[1]  <= in_sel;
                        data_q[1] <= in_data;
                    end
                end
                2'b01: begin
                    // Second entry (if any) advances to head.
                    sel_q[0]  <= sel_q[1];
                    data_q[0] <= data_q[1];
                end
                2'b11: begin
                    // Only reachable with one entry: head leaves, new one takes its place.
                    sel_q[0]  <= in_sel;
                    data_q[0] <= in_data;
                end
                default: ;
            endcase
        end
    end

    assign head_sel  = sel_q[0];
    assign head_data = data_q[0];
    assign next_sel  = sel_q[1];
    assign next_data = data_q[1];
endmodule

// File: rtl/reg_write4.sv
// reg_write4: write side of the 4-register file. Accepts {reg_sel4,wr_data}
// under valid/ready, queues up to two, and commits them in order into A..D,
// one per cycle unless hold freezes write-back.
//   clk, rst        clock, synchronous active-high reset
//   wr_valid/ready  input handshake (ready has no path from wr_valid)
//   wr_data         word to write
//   reg_sel4        destination 0=A 1=B 2=C 3=D
//   hold            1 = no commits this cycle (queue still accepts until full)
//   Aq,Bq,Cq,Dq     register contents
//   busy            a queued write has not committed yet
// Build option: define WB_BYPASS_EN to drive Aq..Dq from the newest queued
// entry targeting each register (forwarded view); stored state is unchanged.
module reg_write4
    import cpu8_pkg::*;
#(
    parameter int            DW      = DW_DEF,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [DW-1:0]   wr_data,
    input  logic [1:0]      reg_sel4,
    input  logic            hold,
    output logic [DW-1:0]   Aq,
    output logic [DW-1:0]   Bq,
    output logic [DW-1:0]   Cq,
    output logic [DW-1:0]   Dq,
    output logic            busy
);
    wb_state_t          state_q, state_d;
    logic               acc, com;
    logic [1:0]         head_sel, next_sel;
    logic [DW-1:0]      head_data, next_data;
    logic [3:0][DW-1:0] regs_q;
    logic [3:0][DW-1:0] view;

    assign wr_ready = (state_q != TWO) && !rst;
    assign busy     = (state_q != EMPTY);
    assign acc      = wr_valid && wr_ready;
    assign com      = !hold && (state_q != EMPTY);

    always_ff @(posedge clk) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (acc) state_d = ONE;
            ONE: begin
                if (acc && !com)      state_d = TWO;
                else if (!acc && com) state_d = EMPTY;
            end
            TWO:   if (com) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    wb_skid_buf #(.DW(DW)) u_q (
        .clk       (clk),
        .rst       (rst),
        .occ       (state_q),
        .push      (acc),
        .pop       (com),
        .in_sel    (reg_sel4),
        .in_data   (wr_data),
        .head_sel  (head_sel),
        .head_data (head_data),
        .next_sel  (next_sel),
        .next_data (next_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 4; r++) regs_q[r] <= RST_VAL;
        end else if (com) begin
            regs_q[head_sel] <= head_data;
        end
    end

    for (genvar r = 0; r < 4; r++) begin : g_view
`ifdef WB_BYPASS_EN
        localparam logic [1:0] RSEL = 2'(r);
        // Newest entry wins: second slot overrides head, head overrides stored.
        always_comb begin
            view[r] = regs_q[r];
            if (state_q != EMPTY && head_sel == RSEL) view[r] = head_data;
            if (state_q == TWO && next_sel == RSEL)   view[r] = next_data;
        end
`else
        assign view[r] = regs_q[r];
`endif
    end

`ifndef WB_BYPASS_EN
    // Queue contents only matter for commit when nothing is forwarded.
    logic unused_next;
    assign unused_next = ^{next_sel, next_data};
`endif

    assign Aq = view[REG_A];
    assign Bq = view[REG_B];
    assign Cq = view[REG_C];
    assign Dq = view[REG_D];
endmodule

// File: tb/tb_reg_write4.sv
module tb_reg_write4;
    logic       clk = 1'b0;
    logic       rst, wr_valid, wr_ready, hold, busy;
    logic [7:0] wr_data, Aq, Bq, Cq, Dq;
    logic [1:0] reg_sel4;

    int  n_cmp = 0;
    int  n_err = 0;
    bit  chk_en = 0;

    // Reference model: ordered queue of {sel,data} plus four registers.
    logic [9:0] m_q[$];
    logic [7:0] m_reg[4];

    always #5 clk = ~clk;

    reg_write4 dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .reg_sel4(reg_sel4), .hold(hold),
        .Aq(Aq), .Bq(Bq), .Cq(Cq), .Dq(Dq), .busy(busy)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_view(input int r);
        logic [7:0] v;
        v = m_reg[r];
`ifdef WB_BYPASS_EN
        foreach (m_q[i]) if (int'(m_q[i][9:8]) == r) v = m_q[i][7:0];
`endif
        return v;
    endfunction

    initial for (int r = 0; r < 4; r++) m_reg[r] = 8'h00;

    always @(posedge clk) begin
        bit         acc, com;
        logic [9:0] e;
        if (rst) begin
            m_q.delete();
            for (int r = 0; r < 4; r++) m_reg[r] = 8'h00;
        end else begin
            acc = wr_valid && (m_q.size() < 2);
            com = !hold && (m_q.size() > 0);
            if (com) begin
                e = m_q.pop_front();
                m_reg[e[9:8]] = e[7:0];
            end
            if (acc) m_q.push_back({reg_sel4, wr_data});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("wr_ready", {7'd0, wr_ready}, {7'd0, (!rst && m_q.size() < 2)});
            check("busy", {7'd0, busy}, {7'd0, (m_q.size() > 0)});
            check("Aq", Aq, m_view(0));
            check("Bq", Bq, m_view(1));
            check("Cq", Cq, m_view(2));
            check("Dq", Dq, m_view(3));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [1:0] s, input logic [7:0] d);
        wr_valid = 1'b1;
        reg_sel4 = s;
        wr_data  = d;
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; reg_sel4 = 2'd0; hold = 1'b0;

        // 1: reset
        step(); chk_en = 1; step();
        check("rst_ready", {7'd0, wr_ready}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_Aq", Aq, 8'h00);
        check("rst_Dq", Dq, 8'h00);
        rst = 1'b0; #1;
        check("rel_ready", {7'd0, wr_ready}, 8'd1);

        // 2: one write per register, previous write lands at the next accept edge
        for (int i = 0; i < 4; i++) begin
            put(2'(i), 8'(i + 1));
            step();
            if (i == 1) check("lat_A", Aq, 8'd1);
            if (i == 3) check("lat_C", Cq, 8'd3);
        end
        wr_valid = 1'b0;
        step();
        check("lat_D", Dq, 8'd4);
        step();
        check("t2_A", Aq, 8'd1);
        check("t2_B", Bq, 8'd2);
        check("t2_C", Cq, 8'd3);
        check("t2_D", Dq, 8'd4);
        check("t2_busy", {7'd0, busy}, 8'd0);

        // 3: hold fills the queue, third write stalls until release
        hold = 1'b1;
        put(2'd1, 8'hAA); step();
        put(2'd2, 8'hBB); step();
        check("t3_full", {7'd0, wr_ready}, 8'd0);
        put(2'd3, 8'hCC); step(); step();
`ifdef WB_BYPASS_EN
        check("t3_Bq_held", Bq, 8'hAA);
        check("t3_Cq_held", Cq, 8'hBB);
`else
        check("t3_Bq_held", Bq, 8'd2);
        check("t3_Cq_held", Cq, 8'd3);
`endif
        hold = 1'b0;
        step();
        check("t3_Bq", Bq, 8'hAA);
        step();
        check("t3_Cq", Cq, 8'hBB);
        wr_valid = 1'b0;
        step();
        check("t3_Dq", Dq, 8'hCC);
        check("t3_busy", {7'd0, busy}, 8'd0);

        // 4: same register twice under hold, later value wins
        hold = 1'b1;
        put(2'd0, 8'h11); step();
        put(2'd0, 8'h22); step();
        wr_valid = 1'b0; step();
`ifdef WB_BYPASS_EN
        check("t4_Aq_held", Aq, 8'h22);
`else
        check("t4_Aq_held", Aq, 8'd1);
`endif
        hold = 1'b0; step(); step();
        check("t4_Aq", Aq, 8'h22);
        check("t4_busy", {7'd0, busy}, 8'd0);

        // 5: reset discards queued writes
        hold = 1'b1;
        put(2'd1, 8'h55); step();
        put(2'd2, 8'h66); step();
        wr_valid = 1'b0; rst = 1'b1; step();
        rst = 1'b0; hold = 1'b0;
        check("t5_Aq", Aq, 8'h00);
        check("t5_Dq", Dq, 8'h00);
        check("t5_busy", {7'd0, busy}, 8'd0);
        step(); step(); step();
        check("t5_Bq", Bq, 8'h00);
        check("t5_Cq", Cq, 8'h00);

        // 6: continuous valid, toggling hold, random traffic
        for (int i = 0; i < 40; i++) begin
            hold = i[0];
            put(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            step();
        end
        wr_valid = 1'b0; hold = 1'b0;
        step(); step(); step();
        check("t6_busy", {7'd0, busy}, 8'd0);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
